// File: rtl/uart_cmd_responder.sv
// Register-access responder behind a UART: 'W',addr,data writes, 'R',addr reads, answers one byte per frame.
// Latency: response o_TX_DV two cycles after the final RX byte; holds in SEND while the transmitter is busy.
module uart_cmd_responder #(
    parameter int CLKS_PER_BIT = 217,
    parameter int NUM_REGS     = 16,
    parameter int TIMEOUT_BITS = 100
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_RX_DV,
    input  logic [7:0]            i_RX_Byte,
    input  logic                  i_TX_Active,
    input  logic                  i_TX_Done,
    output logic                  o_TX_DV,
    output logic [7:0]            o_TX_Byte,
    output logic                  o_Reg_Wr,
    output logic [7:0]            o_Reg_Addr,
    output logic [7:0]            o_Reg_Data,
    output logic [NUM_REGS*8-1:0] o_Regs,
    output logic                  o_Busy,
    output logic [7:0]            o_Err_Count
);
    localparam int         TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int         CW        = $clog2(TO_CYCLES + 1);
    localparam int         IW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [8:0] NREGS     = 9'(NUM_REGS);
    localparam logic [7:0] CH_W = 8'h57, CH_R = 8'h52, CH_K = 8'h4B, CH_Q = 8'h3F;

    typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, SEND, WAIT_DONE} state_t;

    state_t        state, state_nxt;
    logic          op_wr, op_wr_nxt;
    logic [7:0]    addr, addr_nxt;
    logic [7:0]    resp, resp_nxt;
    logic [CW-1:0] tmo_cnt, tmo_cnt_nxt;
    logic [7:0]    regs [NUM_REGS];
    logic          err_inc, tx_fire, wr_fire;
    logic          in_frame, tmo_hit, rx_in_range, addr_in_range;
    logic [IW-1:0] rx_idx, addr_idx;

    assign in_frame      = (state == GET_ADDR) || (state == GET_DATA);
    assign tmo_hit       = in_frame && !i_RX_DV && (tmo_cnt == CW'(TO_CYCLES - 1));
    assign rx_in_range   = {1'b0, i_RX_Byte} < NREGS;
    assign addr_in_range = {1'b0, addr} < NREGS;
    assign rx_idx        = i_RX_Byte[IW-1:0];
    assign addr_idx      = addr[IW-1:0];
    assign o_Busy        = (state != IDLE);

    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) begin
            o_Regs[k*8 +: 8] = regs[k];
        end
    end

    always_comb begin
        state_nxt   = state;
        op_wr_nxt   = op_wr;
        addr_nxt    = addr;
        resp_nxt    = resp;
        err_inc     = 1'b0;
        tx_fire     = 1'b0;
        wr_fire     = 1'b0;
        tmo_cnt_nxt = (in_frame && !i_RX_DV) ? tmo_cnt + CW'(1) : '0;
        case (state)
            IDLE: begin
                if (i_RX_DV) begin
                    if (i_RX_Byte == CH_W) begin
                        op_wr_nxt = 1'b1;
                        state_nxt = GET_ADDR;
                    end else if (i_RX_Byte == CH_R) begin
                        op_wr_nxt = 1'b0;
                        state_nxt = GET_ADDR;
                    end else begin
                        resp_nxt  = CH_Q;
                        err_inc   = 1'b1;
                        state_nxt = SEND;
                    end
                end
            end
            GET_ADDR: begin
                if (i_RX_DV) begin
                    addr_nxt = i_RX_Byte;
                    if (op_wr) begin
                        state_nxt = GET_DATA;
                    end else begin
                        // Index only after the full 8-bit address passed the range check
                        resp_nxt  = rx_in_range ? regs[rx_idx] : CH_Q;
                        err_inc   = !rx_in_range;
                        state_nxt = SEND;
                    end
                end else if (tmo_hit) begin
                    err_inc   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            GET_DATA: begin
                if (i_RX_DV) begin
                    wr_fire   = addr_in_range;
                    resp_nxt  = addr_in_range ? CH_K : CH_Q;
                    err_inc   = !addr_in_range;
                    state_nxt = SEND;
                end else if (tmo_hit) begin
                    err_inc   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            SEND: begin
                err_inc = i_RX_DV;
                if (!i_TX_Active) begin
                    tx_fire   = 1'b1;
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                err_inc = i_RX_DV;
                if (i_TX_Done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state       <= IDLE;
            op_wr       <= 1'b0;
            addr        <= '0;
            resp        <= '0;
            tmo_cnt     <= '0;
            o_TX_DV     <= 1'b0;
            o_TX_Byte   <= '0;
            o_Reg_Wr    <= 1'b0;
            o_Reg_Addr  <= '0;
            o_Reg_Data  <= '0;
            o_Err_Count <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
        end else begin
            state    <= state_nxt;
            op_wr    <= op_wr_nxt;
            addr     <= addr_nxt;
            resp     <= resp_nxt;
            tmo_cnt  <= tmo_cnt_nxt;
            o_TX_DV  <= tx_fire;
            o_Reg_Wr <= wr_fire;
            if (tx_fire) begin
                o_TX_Byte <= resp;
            end
            if (wr_fire) begin
                regs[addr_idx] <= i_RX_Byte;
                o_Reg_Addr     <= addr;
                o_Reg_Data     <= i_RX_Byte;
            end
            if (err_inc && (o_Err_Count != 8'hFF)) begin
                o_Err_Count <= o_Err_Count + 8'd1;
            end
        end
    end
endmodule
